special_insn_ctrl_pipe: RTL and testbench
=========================================

Name: special_insn_ctrl_pipe

Overview:
Pipelined, parametrised successor to the combinational special-instruction decoder. It sits between decode and execute in the pipelined core and decodes LUI, AUIPC, JAL and JALR. It computes the writeback value and the jump target, registers both behind a valid/ready stage, and issues a one-cycle PC redirect. After each redirect it squashes a configurable number of wrong-path beats.

Parameters:
XLEN, 32, datapath width for pc, rs1_data, wb_data and redirect_pc (legal range 32..64).
KILL_CYCLES, 2, number of accepted input beats discarded after a JAL/JALR is accepted; 0 disables squashing.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill from a later stage.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
instr  in  32  instruction word.
pc  in  XLEN  pc of instr.
rs1_data  in  XLEN  rs1 operand, used by JALR.
out_valid  out  1  output register holds a result.
out_ready  in  1  downstream accepts the output.
sel  out  3  111 JALR, 110 JAL, 100 LUI, 101 AUIPC, 000 other.
wb_data  out  XLEN  rd writeback value.
redirect  out  1  one-cycle pc redirect pulse.
redirect_pc  out  XLEN  jump target; valid while redirect=1.
misalign  out  1  target misaligned exception (optional feature only).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, sel=000, wb_data=0, redirect=0, redirect_pc=0, misalign=0, kill counter=0.
- Decode:
  - sel is from instr[6:2]: 11001 JALR, 11011 JAL, 01101 LUI, 00101 AUIPC.
  - If instr[1:0]!=11 or the opcode is any other value, sel=000 and wb_data=0.
- wb_data:
  - LUI: sign-extend {instr[31:12],12'b0} to XLEN.
  - AUIPC: pc + that immediate.
  - JAL and JALR: pc+4.
  - All arithmetic is modulo 2^XLEN.
- Target:
  - JAL: pc + sext(J-imm).
  - JALR: (rs1_data + sext(I-imm)) & ~1.
  - Both wrap modulo 2^XLEN.
- Handshake:
  - in_ready = (!out_valid || out_ready) || kill_cnt!=0.
  - On an accepted non-squashed beat, the output register loads sel and wb_data and out_valid=1. Latency is 1 cycle.
  - Load and unload in the same cycle is a pass-through; the register is replaced and there is no bubble.
  - With out_valid && !out_ready, the register holds and in_ready=0 (unless squashing).
- Redirect:
  - An accepted, non-squashed JAL/JALR sets redirect=1 and loads redirect_pc in the following cycle for exactly one cycle.
  - This happens regardless of out_ready.
- Squash counter:
  - Loaded with KILL_CYCLES in the same edge that accepts a JAL/JALR.
  - While kill_cnt>0, every in_valid beat is accepted, produces no output and no redirect, and decrements the counter.
  - A JAL/JALR inside the window is dropped and does not reload the counter.
  - Cycles with in_valid=0 do not decrement.
  - Counter width is $clog2(KILL_CYCLES+1), minimum 1 bit; with KILL_CYCLES=0 the counter is constant 0.
- Flush (highest priority):
  - Next cycle: out_valid=0, redirect=0, kill_cnt=0.
  - An input beat presented in the same cycle is discarded; in_ready may read 1 but the beat is ignored.
- Reset mid-operation: all of the above return to their reset values immediately (asynchronous).

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined:
  - If an accepted JAL/JALR target has target[1]=1, then misalign=1 together with out_valid, sel is as decoded, and wb_data=0.
  - No redirect is issued and the kill counter is not loaded.
  - misalign clears when the output register is unloaded or flushed.
- Undefined: the misalign port is tied to 0 and the redirect proceeds with the target as computed.

Test Plan:
- Reset then LUI: instr=0x123450B7, pc=0x100, out_ready=1 -> next cycle out_valid=1, sel=100, wb_data=0x12345000, redirect=0.
- AUIPC: instr=0x00001097, pc=0x200 -> sel=101, wb_data=0x1200.
- JAL: instr=0x0080006F, pc=0x300, KILL_CYCLES=2 -> sel=110, wb_data=0x304, redirect pulse of 1 cycle with redirect_pc=0x308. The next 2 valid beats (LUI, AUIPC) are accepted with no out_valid; the third beat produces output.
- JALR: instr=0x004080E7, rs1_data=0x1001, pc=0x40 -> redirect_pc=0x1004 (bit0 cleared), wb_data=0x44. With out_ready=0, the output holds and in_ready=0 for 3 cycles, then drains on out_ready=1.
- Flush: flush=1 in the cycle after a JAL acceptance, with the kill window active -> out_valid=0, kill_cnt=0, and the next beat is decoded normally. rst_n pulsed low mid-window -> all outputs 0 asynchronously.
- With MISALIGN_TRAP_EN: JALR with rs1_data=0x102 and imm=0 -> misalign=1, wb_data=0, no redirect, no squash.

Source files
------------

// File: rtl/special_insn_ctrl_pipe.sv
// special_insn_ctrl_pipe: registered LUI/AUIPC/JAL/JALR decode, redirect
// and wrong-path squash. Optional target trap: MISALIGN_TRAP_EN.
module special_insn_ctrl_pipe #(
  parameter int XLEN        = 32,
  parameter int KILL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      sel,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign
);

  localparam int KW =
    (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;

  logic [KW-1:0]   kill_cnt;
  logic            squash;
  logic            accept;
  logic            take;
  logic            load_jump;
  logic            legal;
  logic            is_jalr;
  logic            is_jal;
  logic            is_lui;
  logic            is_auipc;
  logic            is_jump;
  logic signed [31:0] u_imm32;
  logic signed [20:0] j_imm21;
  logic signed [11:0] i_imm12;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [2:0]      d_sel;
  logic [XLEN-1:0] d_wb;
  logic [XLEN-1:0] d_tgt;
  logic            d_mis;
  logic            unused_rd;

  assign unused_rd = ^instr[11:7];

  assign legal    = (instr[1:0] == 2'b11);
  assign is_jalr  = legal && (instr[6:2] == 5'b11001);
  assign is_jal   = legal && (instr[6:2] == 5'b11011);
  assign is_lui   = legal && (instr[6:2] == 5'b01101);
  assign is_auipc = legal && (instr[6:2] == 5'b00101);
  assign is_jump  = is_jal || is_jalr;

  assign u_imm32 = {instr[31:12], 12'b0};
  assign j_imm21 = {instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
  assign i_imm12 = instr[31:20];
  assign u_imm   = XLEN'(u_imm32);
  assign j_imm   = XLEN'(j_imm21);
  assign i_imm   = XLEN'(i_imm12);
  assign jalr_sum = rs1_data + i_imm;

  // Decode the beat into selector, writeback value and jump target.
  always_comb begin
    d_sel = 3'b000;
    d_wb  = '0;
    d_tgt = '0;
    unique case (1'b1)
      is_jalr: begin
        d_sel = 3'b111;
        d_wb  = pc + XLEN'(4);
        d_tgt = {jalr_sum[XLEN-1:1], 1'b0};
      end
      is_jal: begin
        d_sel = 3'b110;
        d_wb  = pc + XLEN'(4);
        d_tgt = pc + j_imm;
      end
      is_lui: begin
        d_sel = 3'b100;
        d_wb  = u_imm;
      end
      is_auipc: begin
        d_sel = 3'b101;
        d_wb  = pc + u_imm;
      end
      default: ;
    endcase
    if (d_mis) d_wb = '0;
  end

`ifdef MISALIGN_TRAP_EN
  assign d_mis = is_jump && d_tgt[1];
`else
  assign d_mis = 1'b0;
`endif

  assign squash    = (kill_cnt != '0);
  assign in_ready  = !out_valid || out_ready || squash;
  assign accept    = in_valid && in_ready;
  assign take      = accept && !squash && !flush;
  assign load_jump = take && is_jump && !d_mis;

  // Output register: load on a live beat, drain on unload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sel       <= 3'b000;
      wb_data   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      sel       <= d_sel;
      wb_data   <= d_wb;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle redirect pulse for each live jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else if (flush) begin
      redirect    <= 1'b0;
    end else begin
      redirect <= load_jump;
      if (load_jump) redirect_pc <= d_tgt;
    end
  end

  // Wrong-path window: counts down on accepted beats only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_cnt <= '0;
    end else if (flush) begin
      kill_cnt <= '0;
    end else if (load_jump) begin
      kill_cnt <= KW'(KILL_CYCLES);
    end else if (accept && squash) begin
      kill_cnt <= kill_cnt - KW'(1);
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  // Trap flag travels with the output register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (flush) begin
      mis_q <= 1'b0;
    end else if (take) begin
      mis_q <= d_mis;
    end else if (out_valid && out_ready) begin
      mis_q <= 1'b0;
    end
  end

  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_special_insn_ctrl_pipe.sv
// tb_special_insn_ctrl_pipe: scoreboard bench for the special decoder.
// Checks outputs, redirects, handshake, squash, flush and async reset.
module tb_special_insn_ctrl_pipe;

  localparam int KILL = 2;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] wb;
    logic [31:0] tgt;
    logic        jmp;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  sel;
  logic [31:0] wb_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t rd_exp;
  logic rd_due = 1'b0;
  int   m_kill = 0;

  special_insn_ctrl_pipe #(
    .XLEN(32),
    .KILL_CYCLES(KILL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .pc(pc),
    .rs1_data(rs1_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel(sel),
    .wb_data(wb_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] p,
                                 input logic [31:0] r);
    exp_t e;
    logic [31:0] imm;
    e = '0;
    case (i[6:0])
      7'h37: begin
        e.sel = 3'b100;
        e.wb  = {i[31:12], 12'h000};
      end
      7'h17: begin
        e.sel = 3'b101;
        e.wb  = p + {i[31:12], 12'h000};
      end
      7'h6F: begin
        e.sel = 3'b110;
        e.wb  = p + 32'd4;
        imm = {{12{i[31]}}, i[19:12], i[20],
               i[30:21], 1'b0};
        e.tgt = p + imm;
        e.jmp = 1'b1;
      end
      7'h67: begin
        e.sel = 3'b111;
        e.wb  = p + 32'd4;
        imm = {{20{i[31]}}, i[31:20]};
        e.tgt = (r + imm) & 32'hFFFF_FFFE;
        e.jmp = 1'b1;
      end
      default: ;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (e.jmp && e.tgt[1]) begin
      e.mis = 1'b1;
      e.wb  = '0;
      e.jmp = 1'b0;
    end
`endif
    return e;
  endfunction

  // Scoreboard: compare what leaves, then model what enters.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      rd_due = 1'b0;
      m_kill = 0;
    end else begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready,
            (q.size() == 0) || out_ready || (m_kill != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("sel", sel, e.sel);
        check("wb_data", wb_data, e.wb);
        check("misalign", misalign, e.mis);
      end
      if (rd_due) begin
        check("redirect", redirect, 1'b1);
        check("redirect_pc", redirect_pc, rd_exp.tgt);
      end else if (redirect) begin
        check("spurious_redirect", redirect, 1'b0);
      end
      rd_due = 1'b0;
      if (flush) begin
        q.delete();
        m_kill = 0;
      end else if (in_valid && in_ready) begin
        if (m_kill > 0) begin
          m_kill--;
        end else begin
          e = model(instr, pc, rs1_data);
          q.push_back(e);
          if (e.jmp) begin
            rd_due = 1'b1;
            rd_exp = e;
            m_kill = KILL;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (n >= 3) out_ready = 1'b1;
    end
    check("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic present(input logic [31:0] i,
                         input logic [31:0] p,
                         input logic [31:0] r);
    instr    = i;
    pc       = p;
    rs1_data = r;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] i,
                      input logic [31:0] p,
                      input logic [31:0] r);
    present(i, p, r);
    wait_accept();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"}, out_valid, 1'b0);
    check({tag, "_sel"}, sel, 3'b000);
    check({tag, "_wb"}, wb_data, 32'h0);
    check({tag, "_rd"}, redirect, 1'b0);
    check({tag, "_rdpc"}, redirect_pc, 32'h0);
    check({tag, "_mis"}, misalign, 1'b0);
  endtask

  initial begin
    logic [6:0] ops [6];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33};

    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    send(32'h1234_50B7, 32'h100, 32'h0);
    send(32'h0000_1097, 32'h200, 32'h0);
    idle(2);

    send(32'h0080_006F, 32'h300, 32'h0);
    send(32'h1234_50B7, 32'h304, 32'h0);
    send(32'h0000_1097, 32'h308, 32'h0);
    send(32'h1234_50B7, 32'h30C, 32'h0);
    idle(2);

    out_ready = 1'b0;
    send(32'h0040_80E7, 32'h40, 32'h1001);
    send(32'h0000_1097, 32'h44, 32'h0);
    send(32'h0000_1097, 32'h48, 32'h0);
    present(32'h1234_50B7, 32'h1004, 32'h0);
    wait_accept();
    idle(2);

    out_ready = 1'b0;
    send(32'h0080_006F, 32'h300, 32'h0);
    flush = 1'b1;
    present(32'h1234_50B7, 32'h500, 32'h0);
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(32'hFFFF_F0B7, 32'h600, 32'h0);
    idle(2);

    send(32'h0080_006F, 32'h300, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h0000_1097, 32'h200, 32'h0);
    idle(2);

    send(32'h0000_0013, 32'h10, 32'h0);
    send(32'h1234_50B4, 32'h14, 32'h0);
    send(32'h0000_1097, 32'hFFFF_F000, 32'h0);
    send(32'hFFDF_F06F, 32'h0, 32'h0);
    send(32'h0000_0013, 32'h4, 32'h0);
    send(32'h0000_0013, 32'h8, 32'h0);
    send(32'h0000_80E7, 32'h80, 32'h102);
    send(32'h0000_0013, 32'hC, 32'h0);
    send(32'h0000_0013, 32'h10, 32'h0);
    send(32'h1234_50B7, 32'h14, 32'h0);
    idle(2);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 5)];
      out_ready = 1'($urandom_range(0, 1));
      send(w, $urandom & 32'hFFFF_FFFC, $urandom);
    end
    out_ready = 1'b1;
    idle(4);
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
